// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: MDUOp values, FSM states and
// timing constants.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } mdu_state_e;

  localparam int unsigned MUL_CYCLES_DEF = 3;
  localparam int unsigned DIV_ITERS      = 32;

  // Magnitude of a two's-complement word; 0x8000_0000 maps to itself, which is
  // the correct unsigned magnitude.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_hilo_if.sv
// Issue/read bus between the pipeline controller and the HI/LO multiply/divide unit.
interface mdu_hilo_if;
  logic        Start;
  logic [2:0]  MDUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Flush;
  logic        RHLSel;
  logic [31:0] RHLOut;
  logic        Busy;

  modport master (
    output Start, MDUOp, A, B, Flush, RHLSel,
    input  RHLOut, Busy
  );

  modport slave (
    input  Start, MDUOp, A, B, Flush, RHLSel,
    output RHLOut, Busy
  );
endinterface

// File: rtl/mdu_div_core.sv
// Iterative unsigned 32/32 restoring divider, one quotient bit per cycle.
module mdu_div_core
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quot,
  output logic [31:0] rem
);

  logic [31:0] dvsr;
  logic [4:0]  iter;
  logic        active;
  logic [32:0] shifted;
  logic [33:0] trial;

  always_comb begin
    shifted = {rem, quot[31]};
    trial   = {1'b0, shifted} - {2'b00, dvsr};
  end

  // High during the final iteration; quot/rem hold the result after that edge.
  assign done = active && (iter == 5'(DIV_ITERS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quot   <= '0;
      rem    <= '0;
      dvsr   <= '0;
      iter   <= '0;
      active <= 1'b0;
    end else if (abort) begin
      active <= 1'b0;
    end else if (start) begin
      quot   <= dividend;
      rem    <= '0;
      dvsr   <= divisor;
      iter   <= '0;
      active <= 1'b1;
    end else if (active) begin
      if (trial[33]) begin
        rem  <= shifted[31:0];
        quot <= {quot[30:0], 1'b0};
      end else begin
        rem  <= trial[31:0];
        quot <= {quot[30:0], 1'b1};
      end
      iter <= iter + 5'd1;
      if (done) active <= 1'b0;
    end
  end

endmodule

// File: rtl/mdu_hilo.sv
// Multiply/divide unit owning the HI/LO pair; fixed-latency multiply, 33-cycle
// iterative divide, MTHI/MTLO writes, and flush of in-flight operations.
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  mdu_hilo_if.slave  bus
);

  localparam int unsigned CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  mdu_state_e  state, next_state;
  mdu_op_e     op;
  logic [31:0] hi, lo;
  logic [31:0] op_a, op_b;
  logic        is_signed;
  logic [CW-1:0] cnt;

  logic        accept, is_mul_op, is_div_op;
  logic        div_start, div_done;
  logic [31:0] div_quot, div_rem, div_dividend, div_divisor;
  logic [63:0] ext_a, ext_b, product;
  logic [31:0] quot_fix, rem_fix;
  logic        hi_we, lo_we;
  logic [31:0] hi_d, lo_d;

  assign op        = mdu_op_e'(bus.MDUOp);
  assign accept    = (state == S_IDLE) && bus.Start && !bus.Flush;
  assign is_mul_op = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div_op = (op == OP_DIV)  || (op == OP_DIVU);

  assign div_start    = accept && is_div_op;
  assign div_dividend = (op == OP_DIV) ? abs32(bus.A) : bus.A;
  assign div_divisor  = (op == OP_DIV) ? abs32(bus.B) : bus.B;

  mdu_div_core u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .abort    (bus.Flush),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .done     (div_done),
    .quot     (div_quot),
    .rem      (div_rem)
  );

  // Sign-extending only for signed ops lets one 64x64 truncated multiply serve both.
  always_comb begin
    ext_a    = {{32{is_signed & op_a[31]}}, op_a};
    ext_b    = {{32{is_signed & op_b[31]}}, op_b};
    product  = ext_a * ext_b;
    quot_fix = (is_signed && (op_a[31] ^ op_b[31])) ? (~div_quot + 32'd1) : div_quot;
    rem_fix  = (is_signed && op_a[31]) ? (~div_rem + 32'd1) : div_rem;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (bus.Flush) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (bus.Start) begin
          if (is_mul_op)      next_state = S_MUL;
          else if (is_div_op) next_state = S_DIV;
        end
        S_MUL:   if (cnt == '0) next_state = S_IDLE;
        S_DIV:   if (div_done)  next_state = S_FIX;
        S_FIX:   next_state = S_IDLE;
        default: next_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    hi_we = 1'b0;
    lo_we = 1'b0;
    hi_d  = '0;
    lo_d  = '0;
    if (!bus.Flush) begin
      case (state)
        S_IDLE: begin
          if (accept && op == OP_MTHI) begin
            hi_we = 1'b1;
            hi_d  = bus.A;
          end
          if (accept && op == OP_MTLO) begin
            lo_we = 1'b1;
            lo_d  = bus.A;
          end
        end
        S_MUL: if (cnt == '0) begin
          hi_we = 1'b1;
          lo_we = 1'b1;
          hi_d  = product[63:32];
          lo_d  = product[31:0];
        end
        S_FIX: begin
          hi_we = 1'b1;
          lo_we = 1'b1;
          if (op_b == '0) begin
            hi_d = op_a;
            lo_d = '1;
          end else begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi        <= '0;
      lo        <= '0;
      op_a      <= '0;
      op_b      <= '0;
      is_signed <= 1'b0;
      cnt       <= '0;
    end else begin
      if (accept && (is_mul_op || is_div_op)) begin
        op_a      <= bus.A;
        op_b      <= bus.B;
        is_signed <= (op == OP_MULT) || (op == OP_DIV);
      end
      if (accept && is_mul_op)
        cnt <= CW'(MUL_CYCLES - 1);
      else if (state == S_MUL && cnt != '0)
        cnt <= cnt - 1'b1;
      if (hi_we) hi <= hi_d;
      if (lo_we) lo <= lo_d;
    end
  end

  assign bus.RHLOut = bus.RHLSel ? hi : lo;
  assign bus.Busy   = (state != S_IDLE);

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed, table-driven bench for mdu_hilo with hand-written abort/stall/reset sequences.
module tb_mdu_hilo;
  import mdu_pkg::*;

  localparam int unsigned MC = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned checks = 0;
  int unsigned errors = 0;

  mdu_hilo_if bus();

  mdu_hilo #(.MUL_CYCLES(MC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    mdu_op_e     op;
    logic [31:0] a;
    logic [31:0] b;
    int unsigned busy;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic read_hl(output logic [31:0] h, output logic [31:0] l);
    bus.RHLSel = 1'b1; #1; h = bus.RHLOut;
    bus.RHLSel = 1'b0; #1; l = bus.RHLOut;
  endtask

  // Issue at a negedge, then count busy cycles (bounded) until back to idle.
  task automatic run_op(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b,
                        output int unsigned n);
    @(negedge clk);
    bus.Start = 1'b1; bus.MDUOp = op; bus.A = a; bus.B = b;
    @(negedge clk);
    bus.Start = 1'b0;
    n = 0;
    while (bus.Busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic issue(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic flush);
    @(negedge clk);
    bus.Start = 1'b1; bus.MDUOp = op; bus.A = a; bus.B = b; bus.Flush = flush;
    @(negedge clk);
    bus.Start = 1'b0; bus.Flush = 1'b0;
  endtask

  initial begin
    logic [31:0] h, l;
    int unsigned n;

    vecs[0] = '{"mult_neg2x3",   OP_MULT,  32'hFFFF_FFFE, 32'd3,         MC, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[1] = '{"multu_same",    OP_MULTU, 32'hFFFF_FFFE, 32'd3,         MC, 32'h0000_0002, 32'hFFFF_FFFA};
    vecs[2] = '{"mult_min_sq",   OP_MULT,  32'h8000_0000, 32'h8000_0000, MC, 32'h4000_0000, 32'h0000_0000};
    vecs[3] = '{"multu_max_sq",  OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MC, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[4] = '{"div_m7_2",      OP_DIV,   32'hFFFF_FFF9, 32'd2,         33, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[5] = '{"div_7_m2",      OP_DIV,   32'd7,         32'hFFFF_FFFE, 33, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[6] = '{"divu_100_0",    OP_DIVU,  32'd100,       32'd0,         33, 32'd100,       32'hFFFF_FFFF};
    vecs[7] = '{"div_min_m1",    OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0000_0000, 32'h8000_0000};
    vecs[8] = '{"divu_max_16",   OP_DIVU,  32'hFFFF_FFFF, 32'd16,        33, 32'h0000_000F, 32'h0FFF_FFFF};
    vecs[9] = '{"div_m5_0",      OP_DIV,   32'hFFFF_FFFB, 32'd0,         33, 32'hFFFF_FFFB, 32'hFFFF_FFFF};

    bus.Start = 1'b0; bus.MDUOp = 3'd0; bus.A = '0; bus.B = '0;
    bus.Flush = 1'b0; bus.RHLSel = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    read_hl(h, l);
    check("reset_hi", h, 32'h0);
    check("reset_lo", l, 32'h0);
    check("reset_busy", {31'd0, bus.Busy}, 32'd0);
    rst = 1'b0;

    // MTHI / MTLO
    issue(OP_MTHI, 32'h1234_5678, 32'h0, 1'b0);
    check("mthi_busy", {31'd0, bus.Busy}, 32'd0);
    bus.RHLSel = 1'b1; #1;
    check("mthi_read", bus.RHLOut, 32'h1234_5678);
    issue(OP_MTLO, 32'h9ABC_DEF0, 32'h0, 1'b0);
    check("mtlo_busy", {31'd0, bus.Busy}, 32'd0);
    bus.RHLSel = 1'b0; #1;
    check("mtlo_read", bus.RHLOut, 32'h9ABC_DEF0);

    // Table of arithmetic vectors
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, n);
      check({vecs[i].name, "_busy"}, n, vecs[i].busy);
      read_hl(h, l);
      check({vecs[i].name, "_hi"}, h, vecs[i].hi);
      check({vecs[i].name, "_lo"}, l, vecs[i].lo);
    end

    // Flush at cycle 10 of a DIV
    issue(OP_MTHI, 32'hAAAA_5555, 32'h0, 1'b0);
    issue(OP_MTLO, 32'h1234_ABCD, 32'h0, 1'b0);
    issue(OP_DIV, 32'd100, 32'd7, 1'b0);
    repeat (8) @(negedge clk);
    check("flush_prebusy", {31'd0, bus.Busy}, 32'd1);
    bus.Flush = 1'b1;
    @(negedge clk);
    bus.Flush = 1'b0;
    check("flush_busy", {31'd0, bus.Busy}, 32'd0);
    repeat (40) @(negedge clk);
    check("flush_busy_late", {31'd0, bus.Busy}, 32'd0);
    read_hl(h, l);
    check("flush_hi", h, 32'hAAAA_5555);
    check("flush_lo", l, 32'h1234_ABCD);

    // Start during Busy is ignored; RHLOut shows pre-op values meanwhile
    issue(OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
    bus.Start = 1'b1; bus.MDUOp = OP_MTHI; bus.A = 32'hDEAD_BEEF;
    bus.RHLSel = 1'b1; #1;
    check("busy_prehi", bus.RHLOut, 32'hAAAA_5555);
    @(negedge clk);
    bus.Start = 1'b0;
    n = 0;
    while (bus.Busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("stall_busy_tail", n, MC - 1);
    read_hl(h, l);
    check("stall_hi", h, 32'hFFFF_FFFF);
    check("stall_lo", l, 32'hFFFF_FFFA);

    // Flush together with Start: MTLO must not write
    issue(OP_MTLO, 32'h5555_0000, 32'h0, 1'b1);
    check("flushstart_busy", {31'd0, bus.Busy}, 32'd0);
    read_hl(h, l);
    check("flushstart_lo", l, 32'hFFFF_FFFA);
    issue(OP_DIVU, 32'd50, 32'd5, 1'b1);
    check("flushstart_div_busy", {31'd0, bus.Busy}, 32'd0);

    // Reset mid-MUL
    issue(OP_MULT, 32'd7, 32'd9, 1'b0);
    check("rst_prebusy", {31'd0, bus.Busy}, 32'd1);
    rst = 1'b1; #1;
    check("rst_busy", {31'd0, bus.Busy}, 32'd0);
    read_hl(h, l);
    check("rst_hi", h, 32'h0);
    check("rst_lo", l, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    read_hl(h, l);
    check("rst_after_lo", l, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
